hsv_core_commit_flush: RTL and testbench

Commit-side endpoint for execution-unit results. The block consumes `commit_data_t` beats over valid/ready and retires them as register-file writebacks. It counts retired instructions. On a committed control-flow redirect, it runs the `flush_req`/`flush_ack` protocol against all execution units, then hands the new PC to fetch. It is the initiator of the flush handshake that each execution unit answers with a registered `flush_ack`.

---
 rtl/hsv_core_commit_flush.sv | 164 ++++++++++++++++
 tb/tb_hsv_core_commit_flush.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_commit_flush.sv
// hsv_core_commit_flush
//   Commit-side endpoint: retires commit beats as register-file writebacks,
//   counts retired instructions, and on a committed jump runs the
//   flush_req/flush_ack handshake with all execution units before handing
//   the new PC to fetch.
// Ports:
//   clk_core, rst_core_n        clock, async active-low reset
//   commit_data, valid_i/ready_o result beat handshake
//   flush_req / flush_ack       flush broadcast / per-unit acknowledge
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   redirect_valid/_pc/_ready   new fetch PC handshake
//   instret                     64-bit retired-instruction count

package hsv_core_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        jump;
        logic        writeback;
        logic [4:0]  rd;
        logic [31:0] rd_value;
    } commit_data_t;

    localparam int unsigned COMMIT_DATA_W = $bits(commit_data_t);

endpackage

module hsv_core_commit_flush #(
    parameter int unsigned N_UNITS = 4
) (
    input  logic                                   clk_core,
    input  logic                                   rst_core_n,
    input  logic [hsv_core_pkg::COMMIT_DATA_W-1:0] commit_data,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic                                   flush_req,
    input  logic [N_UNITS-1:0]                     flush_ack,
    output logic                                   rf_we,
    output logic [4:0]                             rf_waddr,
    output logic [31:0]                            rf_wdata,
    output logic                                   redirect_valid,
    output logic [31:0]                            redirect_pc,
    input  logic                                   redirect_ready,
    output logic [63:0]                            instret
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    hsv_core_pkg::commit_data_t beat;
    assign beat = hsv_core_pkg::commit_data_t'(commit_data);

    // The retiring PC is carried on the bus but not needed for retirement.
    logic unused_pc_c;
    assign unused_pc_c = ^beat.pc;

    logic [1:0]         state_q, state_d;
    logic               ready_q, ready_d;
    logic               flush_req_q, flush_req_d;
    logic [N_UNITS-1:0] ack_seen_q, ack_seen_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [63:0]        instret_q, instret_d;
    logic               accept_c;

    assign accept_c = valid_i & ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        ack_seen_d    = ack_seen_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        redirect_pc_d = redirect_pc_q;
        instret_d     = instret_q;

        case (state_q)
            RUN: begin
                if (accept_c && beat.jump) begin
                    state_d       = FLUSH;
                    redirect_pc_d = beat.next_pc;
                end
            end
            FLUSH: begin
                // Units may ack in different cycles; remember every bit seen.
                ack_seen_d = ack_seen_q | flush_ack;
                if (&(ack_seen_q | flush_ack)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for acks to fall so they cannot satisfy the next flush.
                if (flush_ack == '0) begin
                    ack_seen_d = '0;
                    state_d    = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (accept_c) begin
            instret_d = instret_q + 64'd1;
            if (beat.writeback && (beat.rd != 5'd0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = beat.rd;
                rf_wdata_d = beat.rd_value;
            end
        end

        // ready rises one cycle after RUN is re-entered and drops on a jump.
        ready_d          = (state_q == RUN) && (state_d == RUN);
        flush_req_d      = (state_d == FLUSH);
        redirect_valid_d = (state_d == REDIRECT);
    end

    // State and output registers
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q          <= RUN;
            ready_q          <= 1'b0;
            flush_req_q      <= 1'b0;
            ack_seen_q       <= '0;
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= 5'd0;
            rf_wdata_q       <= 32'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            instret_q        <= 64'd0;
        end else begin
            state_q          <= state_d;
            ready_q          <= ready_d;
            flush_req_q      <= flush_req_d;
            ack_seen_q       <= ack_seen_d;
            rf_we_q          <= rf_we_d;
            rf_waddr_q       <= rf_waddr_d;
            rf_wdata_q       <= rf_wdata_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            instret_q        <= instret_d;
        end
    end

    assign ready_o        = ready_q;
    assign flush_req      = flush_req_q;
    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_hsv_core_commit_flush.sv
// Directed testbench for hsv_core_commit_flush: writebacks, jump flush
// sequence timing, staggered acks, redirect back-pressure, reset mid-flush
// and instret wrap.
module tb_hsv_core_commit_flush;
    import hsv_core_pkg::*;

    localparam int unsigned N_UNITS = 4;

    logic               clk_core;
    logic               rst_core_n;
    commit_data_t       beat;
    logic               valid_i;
    logic               ready_o;
    logic               flush_req;
    logic [N_UNITS-1:0] flush_ack;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        rf_wdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready;
    logic [63:0]        instret;

    int n_checks;
    int n_errors;
    bit stagger;
    int fr_cnt;

    hsv_core_commit_flush #(.N_UNITS(N_UNITS)) dut (
        .clk_core       (clk_core),
        .rst_core_n     (rst_core_n),
        .commit_data    (beat),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .instret        (instret)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    // Execution-unit model: plain mode acks as a one-cycle copy of flush_req;
    // stagger mode pulses unit u's ack for one cycle, u+1 cycles after request.
    always @(posedge clk_core or negedge rst_core_n) begin
        int cn;
        if (!rst_core_n) begin
            flush_ack <= '0;
            fr_cnt    <= 0;
        end else begin
            cn = flush_req ? fr_cnt + 1 : 0;
            fr_cnt <= cn;
            for (int u = 0; u < int'(N_UNITS); u++) begin
                flush_ack[u] <= stagger ? (flush_req && (cn == u + 1)) : flush_req;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_core);
    endtask

    task automatic drive_beat(input logic [31:0] pc, input logic [31:0] npc, input logic j,
                              input logic wb, input logic [4:0] rd, input logic [31:0] val);
        beat.pc        = pc;
        beat.next_pc   = npc;
        beat.jump      = j;
        beat.writeback = wb;
        beat.rd        = rd;
        beat.rd_value  = val;
        valid_i        = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        stagger        = 1'b0;
        rst_core_n     = 1'b0;
        valid_i        = 1'b0;
        beat           = '0;
        redirect_ready = 1'b1;

        // Reset values
        step();
        step();
        check_eq("rst_ready",   64'(ready_o), 64'd0);
        check_eq("rst_flush",   64'(flush_req), 64'd0);
        check_eq("rst_rf_we",   64'(rf_we), 64'd0);
        check_eq("rst_rv",      64'(redirect_valid), 64'd0);
        check_eq("rst_waddr",   64'(rf_waddr), 64'd0);
        check_eq("rst_wdata",   64'(rf_wdata), 64'd0);
        check_eq("rst_rpc",     64'(redirect_pc), 64'd0);
        check_eq("rst_instret", instret, 64'd0);
        rst_core_n = 1'b1;
        step();
        check_eq("ready_after_rst", 64'(ready_o), 64'd1);

        // Back-to-back writebacks, x0 suppressed
        drive_beat(32'h10, 32'h14, 1'b0, 1'b1, 5'd5, 32'h11);
        step();
        check_eq("wb0_we",    64'(rf_we), 64'd1);
        check_eq("wb0_addr",  64'(rf_waddr), 64'd5);
        check_eq("wb0_data",  64'(rf_wdata), 64'h11);
        check_eq("wb0_ready", 64'(ready_o), 64'd1);
        drive_beat(32'h14, 32'h18, 1'b0, 1'b1, 5'd6, 32'h22);
        step();
        check_eq("wb1_we",    64'(rf_we), 64'd1);
        check_eq("wb1_addr",  64'(rf_waddr), 64'd6);
        check_eq("wb1_data",  64'(rf_wdata), 64'h22);
        check_eq("wb1_ready", 64'(ready_o), 64'd1);
        drive_beat(32'h18, 32'h1c, 1'b0, 1'b1, 5'd0, 32'h33);
        step();
        valid_i = 1'b0;
        check_eq("wb_x0_we",  64'(rf_we), 64'd0);
        check_eq("wb2_ready", 64'(ready_o), 64'd1);
        check_eq("instret3",  instret, 64'd3);

        // Jump with all units acking one cycle later
        drive_beat(32'h100, 32'h2000, 1'b1, 1'b1, 5'd1, 32'h104);
        step(); // t+1
        valid_i = 1'b0;
        check_eq("j_we",      64'(rf_we), 64'd1);
        check_eq("j_addr",    64'(rf_waddr), 64'd1);
        check_eq("j_data",    64'(rf_wdata), 64'h104);
        check_eq("j_ready1",  64'(ready_o), 64'd0);
        check_eq("j_fr1",     64'(flush_req), 64'd1);
        check_eq("j_instret", instret, 64'd4);
        step(); // t+2
        check_eq("j_fr2",     64'(flush_req), 64'd1);
        check_eq("j_we_once", 64'(rf_we), 64'd0);
        step(); // t+3
        check_eq("j_fr3",     64'(flush_req), 64'd0);
        check_eq("j_rv3",     64'(redirect_valid), 64'd0);
        step(); // t+4
        check_eq("j_fr4",     64'(flush_req), 64'd0);
        check_eq("j_rv4",     64'(redirect_valid), 64'd0);
        step(); // t+5
        check_eq("j_rv5",     64'(redirect_valid), 64'd1);
        check_eq("j_rpc5",    64'(redirect_pc), 64'h2000);
        check_eq("j_ready5",  64'(ready_o), 64'd0);
        step(); // t+6
        check_eq("j_rv6",     64'(redirect_valid), 64'd0);
        check_eq("j_ready6",  64'(ready_o), 64'd0);
        step(); // t+7
        check_eq("j_ready7",  64'(ready_o), 64'd1);

        // Staggered acks, then redirect held off for 10 cycles
        stagger        = 1'b1;
        redirect_ready = 1'b0;
        drive_beat(32'h2000, 32'h3000, 1'b1, 1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            valid_i = 1'b0;
            check_eq($sformatf("stag_fr%0d", k), 64'(flush_req), 64'(k <= 5));
            check_eq($sformatf("stag_rv%0d", k), 64'(redirect_valid), 64'(k == 7));
        end
        drive_beat(32'h3000, 32'h3004, 1'b0, 1'b1, 5'd7, 32'h77);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq($sformatf("hold_rv%0d", k),  64'(redirect_valid), 64'd1);
            check_eq($sformatf("hold_rpc%0d", k), 64'(redirect_pc), 64'h3000);
            check_eq($sformatf("hold_rdy%0d", k), 64'(ready_o), 64'd0);
            check_eq($sformatf("hold_we%0d", k),  64'(rf_we), 64'd0);
            check_eq($sformatf("hold_ir%0d", k),  instret, 64'd5);
        end
        valid_i        = 1'b0;
        redirect_ready = 1'b1;
        step();
        check_eq("rel_rv",    64'(redirect_valid), 64'd0);
        check_eq("rel_ready", 64'(ready_o), 64'd0);
        step();
        check_eq("rel_ready2", 64'(ready_o), 64'd1);
        check_eq("rel_instret", instret, 64'd5);

        // Reset asserted while in FLUSH
        stagger = 1'b0;
        drive_beat(32'h3004, 32'h4000, 1'b1, 1'b0, 5'd0, 32'h0);
        step();
        valid_i = 1'b0;
        check_eq("mid_fr", 64'(flush_req), 64'd1);
        rst_core_n = 1'b0;
        #1;
        check_eq("mid_rst_fr",    64'(flush_req), 64'd0);
        check_eq("mid_rst_rv",    64'(redirect_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(ready_o), 64'd0);
        check_eq("mid_rst_ir",    instret, 64'd0);
        check_eq("mid_rst_we",    64'(rf_we), 64'd0);
        step();
        rst_core_n = 1'b1;
        step();
        check_eq("post_rst_ready", 64'(ready_o), 64'd1);
        drive_beat(32'h0, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        valid_i = 1'b0;
        check_eq("post_rst_ir",    instret, 64'd1);
        check_eq("post_rst_fr",    64'(flush_req), 64'd0);
        check_eq("post_rst_ready2", 64'(ready_o), 64'd1);

        // instret wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        check_eq("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_beat(32'h4, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        valid_i = 1'b0;
        check_eq("wrap_post", instret, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
